// File: rtl/cas_loader.sv
// Cassette image loader: buffers HPS download bytes in a small FIFO and writes
// them to SDRAM one at a time, tracking image length and completion.
module cas_loader #(
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter logic [24:0] MAX_LEN    = 25'h0100000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_we,
  input  logic        sdram_ack,
  output logic [24:0] tape_len,
  output logic        tape_ready,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [24:0]      fifo_addr [FIFO_DEPTH];
  logic [7:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             dl_q;
  logic             end_seen;

  logic        dl_rise;
  logic        dl_fall;
  logic        fifo_empty;
  logic        fifo_full;
  logic        in_range;
  logic        wr_req;
  logic        push;
  logic        drop;
  logic        pop;
  logic [24:0] head_addr;
  logic [7:0]  head_data;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign fifo_empty = (count == '0);
  // A restart flushes the FIFO in the same edge, so it never counts as full then
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH)) & ~dl_rise;
  assign in_range   = (ioctl_addr < MAX_LEN);
  assign wr_req     = ioctl_wr & ioctl_download;
  assign push       = wr_req & ~fifo_full & in_range;
  assign drop       = wr_req & (fifo_full | ~in_range);
  assign pop        = (state == WRITE) & sdram_we & sdram_ack & ~dl_rise;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  assign ioctl_wait = (count >= CNT_W'(FIFO_DEPTH - 1)) | (state == DRAIN);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ioctl_addr;
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (dl_rise) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + PTR_W'(push);
      count  <= CNT_W'(push);
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (drop)
        overflow <= 1'b1;
      else if (dl_rise)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      end_seen   <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
      sdram_we   <= 1'b0;
      tape_len   <= '0;
      tape_ready <= 1'b0;
    end else if (dl_rise) begin
      state      <= IDLE;
      end_seen   <= 1'b0;
      sdram_we   <= 1'b0;
      tape_len   <= '0;
      tape_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dl_fall) begin
            state <= DRAIN;
          end else if (!fifo_empty) begin
            sdram_addr <= BASE_ADDR + head_addr;
            sdram_din  <= head_data;
            sdram_we   <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          // An end of download seen mid-write is remembered until the ack
          if (pop) begin
            sdram_we <= 1'b0;
            if (head_addr >= tape_len)
              tape_len <= head_addr + 25'd1;
            state    <= (end_seen || dl_fall) ? DRAIN : IDLE;
            end_seen <= 1'b0;
          end else if (dl_fall) begin
            end_seen <= 1'b1;
          end
        end
        DRAIN: begin
          if (!fifo_empty) begin
            sdram_addr <= BASE_ADDR + head_addr;
            sdram_din  <= head_data;
            sdram_we   <= 1'b1;
            end_seen   <= 1'b1;
            state      <= WRITE;
          end else begin
            tape_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
